// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the state encoding, the NOP word and the instruction field positions.
package instr_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int F3_LSB = 12;
    localparam int F7_LSB = 25;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC arithmetic for the fetch stage.
// Selects the branch or sequential target and flags a non-word-aligned result.
module pc_next_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] immExt_i,
    input  logic            pcSrc_i,
    output logic [XLEN-1:0] next_o,
    output logic [XLEN-1:0] pcPlus4_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] offset;

    assign offset     = pcSrc_i ? immExt_i : 32'd4;
    assign next_o     = pc_i + offset;
    assign pcPlus4_o  = pc_i + 32'd4;
    assign misalign_o = |next_o[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one memory request per instruction, holds the word until accepted.
// Stops for good on a misaligned target or a memory timeout until reset.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcSrc,
    input  logic [31:0] immExt,
    input  logic        instrReady,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        instrValid,
    output logic        misaligned,
    output logic        busErr
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        mis_q, mis_d;
    logic        bus_q, bus_d;

    logic [31:0] next_pc;
    logic        next_mis;
    logic [7:0]  cnt_inc;

    pc_next_calc u_pc_next (
        .pc_i       (pc_q),
        .immExt_i   (immExt),
        .pcSrc_i    (pcSrc),
        .next_o     (next_pc),
        .pcPlus4_o  (pcPlus4),
        .misalign_o (next_mis)
    );

    assign cnt_inc = cnt_q + 8'd1;

    // Out of reset FETCH spends one cycle arming the request register.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        mis_d   = mis_q;
        bus_d   = bus_q;
        unique case (state_q)
            S_FETCH: begin
                cnt_d = 8'd0;
                if (req_q) begin
                    state_d = S_WAIT;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imemValid) begin
                    instr_d = imemRdata;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        bus_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_ISSUE: begin
                if (instrReady) begin
                    if (next_mis) begin
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
        end
    end

    assign imemReq    = req_q;
    assign imemAddr   = pc_q;
    assign instr      = instr_q;
    assign op         = instr_q[OP_LSB +: 7];
    assign f3         = instr_q[F3_LSB +: 3];
    assign f7         = instr_q[F7_LSB +: 7];
    assign pc         = pc_q;
    assign instrValid = (state_q == S_ISSUE);
    assign misaligned = mis_q;
    assign busErr     = bus_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// The bench acts as instruction memory and scores every issued instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcSrc;
    logic [31:0] immExt;
    logic        instrReady;
    logic [31:0] imemRdata;
    logic        imemValid;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        misaligned;
    logic        busErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          lat;
        logic        src;
        logic [31:0] imm;
        logic [31:0] exp_next;
    } vec_t;
    vec_t vt[9];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pcSrc      (pcSrc),
        .immExt     (immExt),
        .instrReady (instrReady),
        .imemRdata  (imemRdata),
        .imemValid  (imemValid),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .instr      (instr),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .instrValid (instrValid),
        .misaligned (misaligned),
        .busErr     (busErr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (imemReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imemReq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_wait actual=no_req required=req@%h", exp_addr);
        end else begin
            chk("imemAddr", imemAddr, exp_addr);
        end
    endtask

    task automatic respond(input int lat, input logic [31:0] word,
                           input logic [31:0] addr);
        sb_t e;
        for (int i = 0; i < lat; i++) @(negedge clk);
        imemValid = 1'b1;
        imemRdata = word;
        e.instr = word;
        e.pc    = addr;
        sbq.push_back(e);
        @(negedge clk);
        imemValid = 1'b0;
        imemRdata = 32'h0;
    endtask

    task automatic check_issue();
        sb_t e;
        int  n = 0;
        while (instrValid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (instrValid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_wait actual=%b required=1", instrValid);
        end else if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard actual=empty required=entry");
        end else begin
            e = sbq.pop_front();
            chk("instr", instr, e.instr);
            chk("op", 32'(op), 32'(e.instr[6:0]));
            chk("f3", 32'(f3), 32'(e.instr[14:12]));
            chk("f7", 32'(f7), 32'(e.instr[31:25]));
            chk("pc", pc, e.pc);
            chk("pcPlus4", pcPlus4, e.pc + 32'd4);
        end
    endtask

    task automatic accept(input logic src, input logic [31:0] imm,
                          input logic exp_fetch);
        pcSrc      = src;
        immExt     = imm;
        instrReady = 1'b1;
        @(negedge clk);
        instrReady = 1'b0;
        pcSrc      = ~src;
        immExt     = $urandom;
        chk("instrValid_drop", 32'(instrValid), 32'd0);
        chk("req_after_accept", 32'(imemReq), 32'(exp_fetch));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        vt[0] = '{32'h0000_0000, 32'h0050_0093, 1,  1'b0, 32'h0,         32'h0000_0004};
        vt[1] = '{32'h0000_0004, 32'h00a0_0113, 1,  1'b0, 32'h0,         32'h0000_0008};
        vt[2] = '{32'h0000_0008, 32'h0000_0013, 1,  1'b1, 32'h8,         32'h0000_0010};
        vt[3] = '{32'h0000_0010, 32'hfe00_08e3, 1,  1'b1, 32'hffff_fff0, 32'h0000_0000};
        vt[4] = '{32'h0000_0000, 32'h0050_0093, 3,  1'b1, 32'h10,        32'h0000_0010};
        vt[5] = '{32'h0000_0010, 32'hfe00_08e3, 1,  1'b0, 32'hffff_fff0, 32'h0000_0014};
        vt[6] = '{32'h0000_0014, 32'h4020_8033, 2,  1'b1, 32'hffff_ffec, 32'h0000_0000};
        vt[7] = '{32'h0000_0000, 32'h00c0_006f, 16, 1'b1, 32'hffff_fffc, 32'hffff_fffc};
        vt[8] = '{32'hffff_fffc, 32'h0000_2083, 1,  1'b0, 32'h0,         32'h0000_0000};

        rst        = 1'b1;
        pcSrc      = 1'b0;
        immExt     = 32'h0;
        instrReady = 1'b0;
        imemRdata  = 32'h0;
        imemValid  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_imemReq", 32'(imemReq), 32'd0);
        chk("rst_instrValid", 32'(instrValid), 32'd0);
        chk("rst_op", 32'(op), 32'h13);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_busErr", 32'(busErr), 32'd0);
        chk("rst_imemAddr", imemAddr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            wait_req(vt[i].addr);
            @(negedge clk);
            chk("req_pulse", 32'(imemReq), 32'd0);
            respond(vt[i].lat - 1, vt[i].word, vt[i].addr);
            check_issue();
            accept(vt[i].src, vt[i].imm, 1'b1);
            chk("next_addr", imemAddr, vt[i].exp_next);
        end

        wait_req(32'h0);
        respond(1, 32'h00c0_0193, 32'h0);
        check_issue();
        for (int i = 0; i < 5; i++) begin
            pcSrc  = ~pcSrc;
            immExt = $urandom;
            @(negedge clk);
            chk("stall_instr", instr, 32'h00c0_0193);
            chk("stall_pc", pc, 32'h0);
            chk("stall_valid", 32'(instrValid), 32'd1);
            chk("stall_req", 32'(imemReq), 32'd0);
        end
        accept(1'b0, 32'h0000_0040, 1'b1);
        chk("stall_next", imemAddr, 32'h4);

        wait_req(32'h4);
        respond(1, 32'h0000_0013, 32'h4);
        check_issue();
        accept(1'b0, 32'h0, 1'b1);
        wait_req(32'h8);
        respond(2, 32'h0010_0093, 32'h8);
        check_issue();
        accept(1'b1, 32'h6, 1'b0);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_pc", pc, 32'h8);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imemReq || instrValid) saw = 1'b1;
        end
        chk("mis_halt", 32'(saw), 32'd0);
        chk("mis_sticky", 32'(misaligned), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        chk("rst2_mis", 32'(misaligned), 32'd0);
        chk("rst2_pc", pc, 32'h0);
        rst = 1'b0;
        wait_req(32'h0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) chk("to_not_yet", 32'(busErr), 32'd0);
        end
        @(negedge clk);
        chk("to_busErr", 32'(busErr), 32'd1);
        imemValid = 1'b1;
        imemRdata = 32'h1234_5678;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            imemValid = 1'b0;
            if (imemReq || instrValid) saw = 1'b1;
        end
        chk("to_halt", 32'(saw), 32'd0);
        chk("to_sticky", 32'(busErr), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_req(32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_busErr", 32'(busErr), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        imemValid = 1'b1;
        imemRdata = 32'hdead_beef;
        @(negedge clk);
        chk("late_req", 32'(imemReq), 32'd1);
        chk("late_addr", imemAddr, 32'h0);
        @(negedge clk);
        imemValid = 1'b0;
        chk("late_ignored", 32'(instrValid), 32'd0);
        @(negedge clk);
        imemValid = 1'b1;
        imemRdata = 32'h0050_0093;
        sbq.push_back('{32'h0050_0093, 32'h0});
        @(negedge clk);
        imemValid = 1'b0;
        check_issue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
